// File: rtl/seg_disp_arbiter.sv
// seg_disp_arbiter: shares one six-digit 74HC595 display datapath between a
// background requester (A) and a priority requester (B). One owner at a
// time, a minimum hold before B may preempt A, and a blank gap of BLANK_CYC
// cycles on every owner change. All outputs are registered.
// Optional: define SEG_ARB_STARVE_EN to let a waiting A force B off the
// display after MAX_HOLD cycles.
module seg_disp_arbiter #(
  parameter int MIN_HOLD  = 25_000_000,
  parameter int BLANK_CYC = 50_000,
  parameter int MAX_HOLD  = 250_000_000,
  parameter int CNT_W     = 28
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        req_a,
  input  logic [19:0] data_a,
  input  logic [5:0]  point_a,
  input  logic        sign_a,
  input  logic        req_b,
  input  logic [19:0] data_b,
  input  logic [5:0]  point_b,
  input  logic        sign_b,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic [19:0] data,
  output logic [5:0]  point,
  output logic        sign,
  output logic        seg_en
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2,
    BLANK = 2'd3
  } state_t;

  // The hold counter saturates at the larger threshold so it can never wrap
  // back below a limit while an owner sits on the display.
  localparam int                HOLD_SAT_I = (MIN_HOLD > MAX_HOLD) ? MIN_HOLD : MAX_HOLD;
  localparam logic [CNT_W-1:0]  HOLD_SAT   = CNT_W'(HOLD_SAT_I);
  localparam logic [CNT_W-1:0]  MIN_HOLD_C = CNT_W'(MIN_HOLD);
  localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] hold_cnt_reg;
  logic [CNT_W-1:0] blank_cnt_reg;
  logic             hold_ge_min;
  logic             blank_done;

  logic             gnt_a_reg,  gnt_a_next;
  logic             gnt_b_reg,  gnt_b_next;
  logic             seg_en_reg, seg_en_next;
  logic [19:0]      data_reg,   data_next;
  logic [5:0]       point_reg,  point_next;
  logic             sign_reg,   sign_next;

  assign hold_ge_min = (hold_cnt_reg >= MIN_HOLD_C);
  assign blank_done  = (blank_cnt_reg == BLANK_LAST);

`ifdef SEG_ARB_STARVE_EN
  localparam logic [CNT_W-1:0] MAX_HOLD_C = CNT_W'(MAX_HOLD);

  logic force_a_reg;
  logic hold_ge_max;

  assign hold_ge_max = (hold_cnt_reg >= MAX_HOLD_C);

  // force_a remembers that B was pushed off for starvation so A wins the
  // next blank exit; it is consumed by any blank exit.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      force_a_reg <= 1'b0;
    end else if (state_reg == GNT_B && state_next == BLANK && req_b) begin
      force_a_reg <= 1'b1;
    end else if (state_reg == BLANK && state_next != BLANK) begin
      force_a_reg <= 1'b0;
    end
  end
`endif

  // State register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decision: B outranks A, release is immediate, preemption of
  // A waits for the minimum hold.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (req_b) begin
          state_next = GNT_B;
        end else if (req_a) begin
          state_next = GNT_A;
        end
      end
      GNT_A: begin
        if (!req_a || (req_b && hold_ge_min)) begin
          state_next = BLANK;
        end
      end
      GNT_B: begin
        if (!req_b) begin
          state_next = BLANK;
        end
`ifdef SEG_ARB_STARVE_EN
        else if (req_a && hold_ge_max) begin
          state_next = BLANK;
        end
`endif
      end
      BLANK: begin
        if (blank_done) begin
`ifdef SEG_ARB_STARVE_EN
          if (force_a_reg && req_a) begin
            state_next = GNT_A;
          end else
`endif
          if (req_b) begin
            state_next = GNT_B;
          end else if (req_a) begin
            state_next = GNT_A;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from the state being entered
  // so the grant and the owner's fields appear one cycle after sampling.
  always_comb begin
    gnt_a_next  = 1'b0;
    gnt_b_next  = 1'b0;
    seg_en_next = 1'b0;
    data_next   = '0;
    point_next  = '0;
    sign_next   = 1'b0;
    case (state_next)
      GNT_A: begin
        gnt_a_next  = 1'b1;
        seg_en_next = 1'b1;
        data_next   = data_a;
        point_next  = point_a;
        sign_next   = sign_a;
      end
      GNT_B: begin
        gnt_b_next  = 1'b1;
        seg_en_next = 1'b1;
        data_next   = data_b;
        point_next  = point_b;
        sign_next   = sign_b;
      end
      default: ;
    endcase
  end

  // Output registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      gnt_a_reg  <= 1'b0;
      gnt_b_reg  <= 1'b0;
      seg_en_reg <= 1'b0;
      data_reg   <= '0;
      point_reg  <= '0;
      sign_reg   <= 1'b0;
    end else begin
      gnt_a_reg  <= gnt_a_next;
      gnt_b_reg  <= gnt_b_next;
      seg_en_reg <= seg_en_next;
      data_reg   <= data_next;
      point_reg  <= point_next;
      sign_reg   <= sign_next;
    end
  end

  // Hold counter: cleared on any state change, counts while an owner stays.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      hold_cnt_reg <= '0;
    end else if (state_next != state_reg) begin
      hold_cnt_reg <= '0;
    end else if ((state_reg == GNT_A || state_reg == GNT_B) && hold_cnt_reg != HOLD_SAT) begin
      hold_cnt_reg <= hold_cnt_reg + 1'b1;
    end
  end

  // Blank counter: runs 0..BLANK_CYC-1 while the blank gap is held.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      blank_cnt_reg <= '0;
    end else if (state_reg == BLANK && state_next == BLANK) begin
      blank_cnt_reg <= blank_cnt_reg + 1'b1;
    end else begin
      blank_cnt_reg <= '0;
    end
  end

  assign gnt_a  = gnt_a_reg;
  assign gnt_b  = gnt_b_reg;
  assign seg_en = seg_en_reg;
  assign data   = data_reg;
  assign point  = point_reg;
  assign sign   = sign_reg;

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// Directed bench for seg_disp_arbiter with MIN_HOLD=4, BLANK_CYC=2,
// MAX_HOLD=10. Starvation checks follow SEG_ARB_STARVE_EN.
module tb_seg_disp_arbiter;

  logic        sys_clk;
  logic        sys_rst;
  logic        req_a;
  logic [19:0] data_a;
  logic [5:0]  point_a;
  logic        sign_a;
  logic        req_b;
  logic [19:0] data_b;
  logic [5:0]  point_b;
  logic        sign_b;
  logic        gnt_a;
  logic        gnt_b;
  logic [19:0] data;
  logic [5:0]  point;
  logic        sign;
  logic        seg_en;

  int n_checks = 0;
  int n_errors = 0;

  seg_disp_arbiter #(
    .MIN_HOLD (4),
    .BLANK_CYC(2),
    .MAX_HOLD (10),
    .CNT_W    (28)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .req_a  (req_a),
    .data_a (data_a),
    .point_a(point_a),
    .sign_a (sign_a),
    .req_b  (req_b),
    .data_b (data_b),
    .point_b(point_b),
    .sign_b (sign_b),
    .gnt_a  (gnt_a),
    .gnt_b  (gnt_b),
    .data   (data),
    .point  (point),
    .sign   (sign),
    .seg_en (seg_en)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic ga, input logic gb, input logic en,
                            input logic [19:0] d, input logic [5:0] p, input logic s);
    $display("step %s: gnt_a=%0b gnt_b=%0b seg_en=%0b data=%0d point=%b sign=%0b",
             tag, gnt_a, gnt_b, seg_en, data, point, sign);
    check({tag, ".gnt_a"},  32'(gnt_a),  32'(ga));
    check({tag, ".gnt_b"},  32'(gnt_b),  32'(gb));
    check({tag, ".seg_en"}, 32'(seg_en), 32'(en));
    check({tag, ".data"},   32'(data),   32'(d));
    check({tag, ".point"},  32'(point),  32'(p));
    check({tag, ".sign"},   32'(sign),   32'(s));
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Grants are mutually exclusive and the display is on only with an owner.
  always @(negedge sys_clk) begin
    if (sys_rst === 1'b0) begin
      check("excl", 32'(gnt_a & gnt_b), 32'd0);
      check("en_vs_gnt", 32'(seg_en), 32'(gnt_a ^ gnt_b));
    end
  end

  initial begin
    sys_rst = 1'b1;
    req_a = 1'b0; data_a = '0; point_a = '0; sign_a = 1'b0;
    req_b = 1'b0; data_b = '0; point_b = '0; sign_b = 1'b0;
    step();
    step();
    expect_out("reset", 0, 0, 0, 20'd0, 6'd0, 0);
    sys_rst = 1'b0;
    step();
    expect_out("idle", 0, 0, 0, 20'd0, 6'd0, 0);

    // A alone: grant one cycle later, data follows with one cycle latency.
    req_a = 1'b1; data_a = 20'd123456; point_a = 6'b001010; sign_a = 1'b1;
    step();
    expect_out("a_grant", 1, 0, 1, 20'd123456, 6'b001010, 1);
    data_a = 20'd654321; point_a = 6'b110000; sign_a = 1'b0;
    step();
    expect_out("a_follow", 1, 0, 1, 20'd654321, 6'b110000, 0);
    req_a = 1'b0;
    step();
    expect_out("a_rel_blank0", 0, 0, 0, 20'd0, 6'd0, 0);
    step();
    expect_out("a_rel_blank1", 0, 0, 0, 20'd0, 6'd0, 0);
    step();
    expect_out("a_rel_idle", 0, 0, 0, 20'd0, 6'd0, 0);

    // Both requesters together from IDLE: B wins.
    data_b = 20'hABCDE; point_b = 6'b111111; sign_b = 1'b1;
    data_a = 20'd123456;
    req_a = 1'b1; req_b = 1'b1;
    step();
    expect_out("both_b_wins", 0, 1, 1, 20'hABCDE, 6'b111111, 1);
    req_a = 1'b0; req_b = 1'b0;
    step();
    expect_out("both_blank0", 0, 0, 0, 20'd0, 6'd0, 0);
    step();
    expect_out("both_blank1", 0, 0, 0, 20'd0, 6'd0, 0);
    step();
    expect_out("both_idle", 0, 0, 0, 20'd0, 6'd0, 0);

    // Preemption of A by B only after the minimum hold.
    req_a = 1'b1;
    step();
    expect_out("pre_a_h0", 1, 0, 1, 20'd123456, 6'b110000, 0);
    step();
    expect_out("pre_a_h1", 1, 0, 1, 20'd123456, 6'b110000, 0);
    req_b = 1'b1;
    step();
    expect_out("pre_a_h2", 1, 0, 1, 20'd123456, 6'b110000, 0);
    step();
    expect_out("pre_a_h3", 1, 0, 1, 20'd123456, 6'b110000, 0);
    step();
    expect_out("pre_a_h4", 1, 0, 1, 20'd123456, 6'b110000, 0);
    step();
    expect_out("pre_blank0", 0, 0, 0, 20'd0, 6'd0, 0);
    req_a = 1'b0;
    step();
    expect_out("pre_blank1", 0, 0, 0, 20'd0, 6'd0, 0);
    step();
    expect_out("pre_b_grant", 0, 1, 1, 20'hABCDE, 6'b111111, 1);

    // B releases with nobody waiting: blank then IDLE.
    req_b = 1'b0;
    step();
    expect_out("brel_blank0", 0, 0, 0, 20'd0, 6'd0, 0);
    step();
    expect_out("brel_blank1", 0, 0, 0, 20'd0, 6'd0, 0);
    step();
    expect_out("brel_idle", 0, 0, 0, 20'd0, 6'd0, 0);

    // B drops and returns inside the blank: re-granted at blank exit.
    req_b = 1'b1;
    step();
    expect_out("reb_grant", 0, 1, 1, 20'hABCDE, 6'b111111, 1);
    req_b = 1'b0;
    step();
    expect_out("reb_blank0", 0, 0, 0, 20'd0, 6'd0, 0);
    req_b = 1'b1;
    step();
    expect_out("reb_blank1", 0, 0, 0, 20'd0, 6'd0, 0);
    step();
    expect_out("reb_regrant", 0, 1, 1, 20'hABCDE, 6'b111111, 1);

    // Asynchronous reset between edges clears outputs at once.
    #2;
    sys_rst = 1'b1;
    #1;
    expect_out("async_rst", 0, 0, 0, 20'd0, 6'd0, 0);
    step();
    expect_out("rst_held", 0, 0, 0, 20'd0, 6'd0, 0);
    sys_rst = 1'b0;
    step();
    expect_out("rst_regrant", 0, 1, 1, 20'hABCDE, 6'b111111, 1);

    // A waits while B holds the display.
    req_a = 1'b1;
`ifdef SEG_ARB_STARVE_EN
    for (int i = 1; i <= 10; i++) begin
      step();
      expect_out($sformatf("starve_b_h%0d", i), 0, 1, 1, 20'hABCDE, 6'b111111, 1);
    end
    step();
    expect_out("starve_blank0", 0, 0, 0, 20'd0, 6'd0, 0);
    step();
    expect_out("starve_blank1", 0, 0, 0, 20'd0, 6'd0, 0);
    step();
    expect_out("starve_a_grant", 1, 0, 1, 20'd123456, 6'b110000, 0);
    for (int i = 1; i <= 4; i++) begin
      step();
      expect_out($sformatf("starve_a_h%0d", i), 1, 0, 1, 20'd123456, 6'b110000, 0);
    end
    step();
    expect_out("regain_blank0", 0, 0, 0, 20'd0, 6'd0, 0);
    step();
    expect_out("regain_blank1", 0, 0, 0, 20'd0, 6'd0, 0);
    step();
    expect_out("b_regain", 0, 1, 1, 20'hABCDE, 6'b111111, 1);
`else
    begin
      int held;
      held = 0;
      for (int i = 0; i < 120; i++) begin
        step();
        if (gnt_b === 1'b1 && gnt_a === 1'b0) held++;
      end
      $display("step no_starve: gnt_b held %0d of 120 cycles", held);
      check("no_starve", 32'(held), 32'd120);
    end
`endif

    req_a = 1'b0; req_b = 1'b0;
    step();
    step();
    step();
    expect_out("final_idle", 0, 0, 0, 20'd0, 6'd0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
